// File: rtl/bus_pkg.sv
// Shared types and widths for the serial bus master port.
package bus_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BIT_W  = $clog2(DATA_W);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    ADDR      = 3'd2,
    WAIT_AACK = 3'd3,
    WDATA     = 3'd4,
    WAIT_WACK = 3'd5,
    RDATA     = 3'd6,
    DONE      = 3'd7
  } state_e;

endpackage

// File: rtl/counter.sv
// Up-counter with synchronous clear and enable; exposes its next value for
// look-ahead output registering.
module counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count_q,
  output logic [WIDTH-1:0] count_d_c
);

  always_comb begin
    count_d_c = count_q;
    if (clr) begin
      count_d_c = '0;
    end else if (en) begin
      count_d_c = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d_c;
    end
  end

endmodule

// File: rtl/master_serial_port.sv
// Serial bus master: arbitrates, shifts address/write data out LSB first,
// collects read data honouring slave-busy, and reports ACK timeouts.
module master_serial_port
  import bus_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              M_START,
  input  logic              M_RW,
  input  logic [ADDR_W-1:0] M_ADDR,
  input  logic [DATA_W-1:0] M_WDATA,
  output logic              M_BUSY,
  output logic              M_DONE,
  output logic [DATA_W-1:0] M_RDATA,
  output logic              M_ERR,
  output logic              B_REQ,
  input  logic              B_GRANT,
  output logic              B_AVALID,
  output logic              B_RW,
  output logic              B_BUS_OUT,
  input  logic              B_BUS_IN,
  input  logic              B_ACK,
  input  logic              B_SBSY
);

  localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              seen_q, seen_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] m_rdata_q, m_rdata_d;
  logic              err_q, err_d;
  logic              breq_q, breq_d;
  logic              avalid_q, avalid_d;
  logic              brw_q, brw_d;
  logic              bus_out_q, bus_out_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cnt_clr, cnt_en;

  // Bit index for ADDR/WDATA/RDATA; cleared on every state change.
  counter #(.WIDTH(CNT_W)) u_bit_cnt (
    .clk       (CLK),
    .rst       (RST),
    .clr       (cnt_clr),
    .en        (cnt_en),
    .count_q   (cnt_q),
    .count_d_c (cnt_d)
  );

  // Next state, datapath and look-ahead output values.
  always_comb begin
    state_d   = state_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    tmo_d     = tmo_q;
    seen_d    = seen_q;
    err_d     = err_q;
    m_rdata_d = m_rdata_q;
    cnt_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (M_START) begin
          state_d = REQ;
          rw_d    = M_RW;
          addr_d  = M_ADDR;
          wdata_d = M_WDATA;
          err_d   = 1'b0;
        end
      end
      REQ: begin
        if (B_GRANT) state_d = ADDR;
      end
      ADDR: begin
        if (cnt_q == CNT_W'(ADDR_W - 1)) state_d = WAIT_AACK;
        else cnt_en = 1'b1;
      end
      WAIT_AACK, WAIT_WACK: begin
        // An ACK high-then-low handshake ends the wait; only a silent slave times out.
        if (B_ACK) begin
          seen_d = 1'b1;
          tmo_d  = '0;
        end else if (seen_q) begin
          if (state_q == WAIT_WACK) state_d = DONE;
          else state_d = rw_q ? WDATA : RDATA;
        end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      WDATA: begin
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = WAIT_WACK;
        else cnt_en = 1'b1;
      end
      RDATA: begin
        if (!B_SBSY) begin
          rdata_d[cnt_q[BIT_W-1:0]] = B_BUS_IN;
          if (cnt_q == CNT_W'(DATA_W - 1)) state_d = DONE;
          else cnt_en = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cnt_clr = (state_d != state_q);
    if (state_d != state_q) begin
      seen_d = 1'b0;
      tmo_d  = '0;
    end

    if (state_d == DONE && !rw_q && !err_d) m_rdata_d = rdata_d;

    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    breq_d    = (state_d != IDLE) && (state_d != DONE);
    avalid_d  = (state_d == ADDR);
    brw_d     = (state_d != IDLE) && rw_d;
    bus_out_d = 1'b0;
    if (state_d == ADDR) bus_out_d = addr_d[cnt_d];
    else if (state_d == WDATA) bus_out_d = wdata_d[cnt_d[BIT_W-1:0]];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      tmo_q     <= '0;
      seen_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      m_rdata_q <= '0;
      err_q     <= 1'b0;
      breq_q    <= 1'b0;
      avalid_q  <= 1'b0;
      brw_q     <= 1'b0;
      bus_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      tmo_q     <= tmo_d;
      seen_q    <= seen_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      m_rdata_q <= m_rdata_d;
      err_q     <= err_d;
      breq_q    <= breq_d;
      avalid_q  <= avalid_d;
      brw_q     <= brw_d;
      bus_out_q <= bus_out_d;
    end
  end

  assign M_BUSY    = busy_q;
  assign M_DONE    = done_q;
  assign M_RDATA   = m_rdata_q;
  assign M_ERR     = err_q;
  assign B_REQ     = breq_q;
  assign B_AVALID  = avalid_q;
  assign B_RW      = brw_q;
  assign B_BUS_OUT = bus_out_q;

endmodule

// File: tb/tb_master_serial_port.sv
// Directed bench for master_serial_port: a slave/arbiter driver plus
// scoreboard monitors for completions and serialised addresses.
module tb_master_serial_port;

  localparam int unsigned TMO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_start = 1'b0, m_rw = 1'b0;
  logic [15:0] m_addr = '0;
  logic [7:0]  m_wdata = '0;
  logic        m_busy, m_done, m_err;
  logic [7:0]  m_rdata;
  logic        b_req, b_avalid, b_rw, b_bus_out;
  logic        b_grant = 1'b0, b_bus_in = 1'b0, b_ack = 1'b0, b_sbsy = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         lat;
    int         start;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] addr_q[$];
  exp_t        mon_e;
  logic [15:0] abuf = '0;
  int          acnt = 0;
  logic        prev_avalid = 1'b0;

  master_serial_port #(.ACK_TIMEOUT(TMO)) dut (
    .CLK(clk), .RST(rst), .M_START(m_start), .M_RW(m_rw), .M_ADDR(m_addr),
    .M_WDATA(m_wdata), .M_BUSY(m_busy), .M_DONE(m_done), .M_RDATA(m_rdata),
    .M_ERR(m_err), .B_REQ(b_req), .B_GRANT(b_grant), .B_AVALID(b_avalid),
    .B_RW(b_rw), .B_BUS_OUT(b_bus_out), .B_BUS_IN(b_bus_in), .B_ACK(b_ack),
    .B_SBSY(b_sbsy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Completion scoreboard, address collector and idle-quiet check.
  always @(negedge clk) begin
    if (m_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_rdata", 32'(m_rdata), 32'(mon_e.rdata));
        check("done_err", 32'(m_err), 32'(mon_e.err));
        check("done_breq_low", 32'(b_req), 32'd0);
        if (mon_e.lat != 0) check("done_latency", 32'(cyc - mon_e.start + 1), 32'(mon_e.lat));
      end
    end
    if (b_avalid === 1'b1) begin
      if (acnt < 16) abuf[acnt[3:0]] = b_bus_out;
      acnt++;
    end else if (prev_avalid) begin
      if (addr_q.size() == 0) check("unexpected_addr", 32'd1, 32'd0);
      else begin
        check("addr_bits", 32'(abuf), 32'(addr_q.pop_front()));
        check("addr_len", 32'(acnt), 32'd16);
      end
      acnt = 0;
    end
    prev_avalid = (b_avalid === 1'b1);
    if (m_busy === 1'b0 && !rst)
      check("idle_quiet", 32'({m_done, b_req, b_avalid, b_rw, b_bus_out}), 32'd0);
  end

  task automatic start(input logic rw, input logic [15:0] a, input logic [7:0] wd,
                       input logic push, input logic [7:0] erd, input logic eerr, input int lat);
    m_start = 1'b1; m_rw = rw; m_addr = a; m_wdata = wd;
    addr_q.push_back(a);
    if (push) exp_q.push_back('{erd, eerr, lat, cyc});
    tick();
    m_start = 1'b0;
  endtask

  // Holds grant low for d REQ cycles; optionally pulses a stray M_START at cycle poke.
  task automatic grant(input int d, input int poke);
    int low = 0;
    for (int i = 0; i <= d; i++) begin
      if (b_req !== 1'b1) low++;
      b_grant = (i == d);
      if (i == poke) begin
        m_start = 1'b1; m_rw = 1'b0; m_addr = 16'hFFFF; m_wdata = 8'h00;
      end else m_start = 1'b0;
      tick();
    end
    b_grant = 1'b0;
    m_start = 1'b0;
    check("breq_in_req", 32'(low), 32'd0);
  endtask

  task automatic wait_addr();
    int n = 0;
    while (b_avalid === 1'b1 && n < 40) begin tick(); n++; end
    check("addr_phase_cycles", 32'(n), 32'd16);
  endtask

  task automatic ack2();
    b_ack = 1'b1; tick(); tick();
    b_ack = 1'b0; tick();
  endtask

  task automatic write_byte(input logic [7:0] wd);
    logic [7:0] b = '0;
    for (int i = 0; i < 8; i++) begin
      b[i] = b_bus_out;
      tick();
    end
    check("wdata_bits", 32'(b), 32'(wd));
  endtask

  // Serves 8 bits; a busy window of blen cycles starting at cycle bat drives wrong data.
  task automatic read_byte(input logic [7:0] d, input int bat, input int blen);
    int k = 0;
    for (int c = 0; c < 8 + blen; c++) begin
      if (c >= bat && c < bat + blen) begin
        b_sbsy = 1'b1; b_bus_in = ~d[k];
      end else begin
        b_sbsy = 1'b0; b_bus_in = d[k]; k++;
      end
      tick();
    end
    b_sbsy = 1'b0; b_bus_in = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_busy !== 1'b0 && n < 100) begin tick(); n++; end
    check("returned_idle", 32'(m_busy), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("reset_outputs", 32'({m_busy, m_done, m_rdata, m_err, b_req, b_avalid, b_rw, b_bus_out}), 32'd0);
    tick();

    // Write 0x1234 / 0xA5, immediate grant, 2-cycle ACKs: 1+1+16+3+8+3+1 cycles.
    start(1'b1, 16'h1234, 8'hA5, 1'b1, 8'h00, 1'b0, 33);
    check("brw_write", 32'(b_rw), 32'd1);
    grant(0, -1);
    wait_addr();
    ack2();
    write_byte(8'hA5);
    ack2();
    wait_idle();

    // Read 0x0008 returning 0x3C with 5 busy cycles mid-byte: 1+1+16+3+13+1.
    start(1'b0, 16'h0008, 8'h00, 1'b1, 8'h3C, 1'b0, 35);
    check("brw_read", 32'(b_rw), 32'd0);
    grant(0, -1);
    wait_addr();
    ack2();
    read_byte(8'h3C, 4, 5);
    wait_idle();

    // Silent slave: timeout 15 cycles after address; read data stays 0x3C.
    start(1'b0, 16'h4321, 8'h00, 1'b1, 8'h3C, 1'b1, 1 + 1 + 16 + TMO + 1);
    grant(0, -1);
    wait_addr();
    wait_idle();
    check("err_held", 32'(m_err), 32'd1);

    // 20-cycle grant delay with a stray M_START in REQ; err cleared by start.
    start(1'b1, 16'h00F0, 8'h5A, 1'b1, 8'h3C, 1'b0, 33 + 20);
    check("err_cleared", 32'(m_err), 32'd0);
    grant(20, 10);
    wait_addr();
    ack2();
    write_byte(8'h5A);
    ack2();
    wait_idle();
    repeat (3) tick();
    check("single_txn", 32'(m_busy), 32'd0);

    // Reset in the fifth WDATA cycle, with a coincident M_START that must be dropped.
    start(1'b1, 16'h0F0F, 8'hC3, 1'b0, 8'h00, 1'b0, 0);
    grant(0, -1);
    wait_addr();
    ack2();
    repeat (4) tick();
    rst = 1'b1; m_start = 1'b1; m_rw = 1'b1; m_addr = 16'h7777;
    tick();
    rst = 1'b0; m_start = 1'b0;
    check("mid_reset_outputs", 32'({m_busy, m_done, m_rdata, m_err, b_req, b_avalid, b_rw, b_bus_out}), 32'd0);
    tick();
    check("start_dropped", 32'(m_busy), 32'd0);

    // Normal write after reset; M_RDATA was cleared by reset.
    start(1'b1, 16'h8001, 8'h81, 1'b1, 8'h00, 1'b0, 33);
    grant(0, -1);
    wait_addr();
    ack2();
    write_byte(8'h81);
    ack2();
    wait_idle();

    // Read with busy in the very first RDATA cycle: 1+1+16+3+10+1.
    start(1'b0, 16'hBEEF, 8'h00, 1'b1, 8'h96, 1'b0, 32);
    grant(0, -1);
    wait_addr();
    ack2();
    read_byte(8'h96, 0, 2);
    wait_idle();

    repeat (3) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("addr_queue_drained", 32'(addr_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
